// File: rtl/fir_linear_interpolator.sv
// Linear-interpolation upsampler: each accepted sample produces L = 2^LOG2L outputs
// that ramp from the previous sample toward the new one (triangular kernel).
module fir_linear_interpolator #(
    parameter int N     = 16,
    parameter int LOG2L = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int L = 1 << LOG2L;
    localparam logic [LOG2L-1:0] K_LAST = LOG2L'(L - 1);
    localparam int AW = N + LOG2L;

    // Valid/ready: a transfer happens on a rising edge where valid & ready are both high;
    // the source holds data until accepted, and out_data is stable while out_ready is low.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     x_prev_q, x_prev_d;
    logic [N-1:0]     x_cur_q, x_cur_d;
    logic [LOG2L-1:0] k_q, k_d;
    logic [N-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic out_fire;
    logic last_phase;

    // Weighted sum fits in N+LOG2L bits because the weights add up to exactly L.
    function automatic logic [N-1:0] blend(input logic [N-1:0] xp,
                                           input logic [N-1:0] xc,
                                           input logic [LOG2L-1:0] kk);
        logic [LOG2L:0] wk;
        logic [LOG2L:0] wp;
        logic [AW-1:0]  acc;
        wk  = {1'b0, kk};
        wp  = (LOG2L + 1)'(L) - wk;
        acc = AW'(xp) * AW'(wp) + AW'(xc) * AW'(wk);
        return N'(acc >> LOG2L);
    endfunction

    assign out_fire   = out_valid_q & out_ready;
    assign last_phase = (k_q == K_LAST);

    // Accepting on the last phase lets back-to-back bursts run without a bubble.
    assign in_ready  = (state_q == IDLE) | ((state_q == RUN) & last_phase & out_ready);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        x_prev_d    = x_prev_q;
        x_cur_d     = x_cur_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    x_cur_d     = in_data;
                    k_d         = '0;
                    out_data_d  = x_prev_q;
                    out_valid_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (out_fire) begin
                    if (!last_phase) begin
                        k_d        = k_q + LOG2L'(1);
                        out_data_d = blend(x_prev_q, x_cur_q, k_q + LOG2L'(1));
                    end else begin
                        x_prev_d = x_cur_q;
                        k_d      = '0;
                        if (in_valid) begin
                            // Phase 0 of the next burst is the sample just finished.
                            x_cur_d    = in_data;
                            out_data_d = x_cur_q;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_prev_q    <= '0;
            x_cur_q     <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_prev_q    <= x_prev_d;
            x_cur_q     <= x_cur_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_linear_interpolator.sv
// Bench for fir_linear_interpolator: L=4 and L=2 instances, scoreboard of expected
// interpolated samples computed from the previous/current input with plain arithmetic.
module tb_fir_linear_interpolator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [15:0] in_data_a = '0;
    logic        in_valid_a = 1'b0;
    logic        in_ready_a;
    logic [15:0] out_data_a;
    logic        out_valid_a;
    logic        out_ready_a = 1'b1;

    logic [15:0] in_data_b = '0;
    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [15:0] out_data_b;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    int          prev_a = 0;
    int          prev_b = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rand_ready = 1'b0;

    fir_linear_interpolator #(.N(16), .LOG2L(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    fir_linear_interpolator #(.N(16), .LOG2L(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_val(input int p, input int c, input int k, input int l);
        longint s;
        s = longint'(p) * longint'(l - k) + longint'(c) * longint'(k);
        return 16'(s / l);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                out_ready_a = 1'($urandom_range(0, 1));
                out_ready_b = 1'($urandom_range(0, 1));
            end
        end
    end

    // scoreboard monitor, instance A (L=4)
    initial begin
        logic        hold;
        logic [15:0] held;
        logic [15:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q_a.delete();
                prev_a = 0;
                hold   = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid_a", int'(out_valid_a), 1);
                    chk("hold_data_a", int'(out_data_a), int'(held));
                end
                hold = out_valid_a && !out_ready_a;
                held = out_data_a;
                if (out_valid_a && out_ready_a) begin
                    if (exp_q_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_a: got %0d expected no output", out_data_a);
                    end else begin
                        e = exp_q_a.pop_front();
                        chk("out_data_a", int'(out_data_a), int'(e));
                    end
                end
                if (in_valid_a && in_ready_a) begin
                    for (int k = 0; k < 4; k++) exp_q_a.push_back(ref_val(prev_a, int'(in_data_a), k, 4));
                    prev_a = int'(in_data_a);
                end
            end
        end
    end

    // scoreboard monitor, instance B (L=2)
    initial begin
        logic        hold;
        logic [15:0] held;
        logic [15:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q_b.delete();
                prev_b = 0;
                hold   = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid_b", int'(out_valid_b), 1);
                    chk("hold_data_b", int'(out_data_b), int'(held));
                end
                hold = out_valid_b && !out_ready_b;
                held = out_data_b;
                if (out_valid_b && out_ready_b) begin
                    if (exp_q_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_b: got %0d expected no output", out_data_b);
                    end else begin
                        e = exp_q_b.pop_front();
                        chk("out_data_b", int'(out_data_b), int'(e));
                    end
                end
                if (in_valid_b && in_ready_b) begin
                    for (int k = 0; k < 2; k++) exp_q_b.push_back(ref_val(prev_b, int'(in_data_b), k, 2));
                    prev_b = int'(in_data_b);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input int sel, input logic [15:0] v, output int cycles);
        logic acc;
        cycles = 0;
        acc    = 1'b0;
        if (sel == 0) begin in_data_a = v; in_valid_a = 1'b1; end
        else          begin in_data_b = v; in_valid_b = 1'b1; end
        while (!acc && cycles < 64) begin
            @(negedge clk);
            acc = (sel == 0) ? in_ready_a : in_ready_b;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drop(input int sel, input int idle);
        if (sel == 0) in_valid_a = 1'b0;
        else          in_valid_b = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", (sel == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int c;
        logic [15:0] v;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_a", int'(out_valid_a), 0);
        chk("reset_data_a", int'(out_data_a), 0);
        chk("reset_ready_a", int'(in_ready_a), 1);
        chk("reset_valid_b", int'(out_valid_b), 0);
        reset = 1'b0;

        // basic burst, idle gap, then backpressure on the 100->200 burst
        send(0, 16'd100, c);
        chk("idle_accept_cycles", c, 1);
        drop(0, 6);
        chk("gap_valid_a", int'(out_valid_a), 0);
        send(0, 16'd200, c);
        drop(0, 0);
        chk("bp_phase0", int'(out_data_a), 100);
        @(posedge clk);
        #1;
        chk("bp_phase1", int'(out_data_a), 125);
        out_ready_a = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_data", int'(out_data_a), 125);
            chk("bp_valid", int'(out_valid_a), 1);
            chk("bp_in_ready", int'(in_ready_a), 0);
            chk("bp_k", int'(u_dut_a.k_q), 1);
        end
        out_ready_a = 1'b1;
        drain(0);

        // back-to-back bursts
        do_reset();
        send(0, 16'h0010, c);
        send(0, 16'h0020, c);
        chk("b2b_gap1", c, 4);
        send(0, 16'h0030, c);
        chk("b2b_gap2", c, 4);
        drop(0, 0);
        drain(0);

        // full-scale ramp down
        send(0, 16'hFFFF, c);
        drop(0, 0);
        drain(0);
        send(0, 16'h0000, c);
        drop(0, 0);
        @(posedge clk);
        #1;
        chk("fullscale_phase1", int'(out_data_a), 16'hBFFF);
        drain(0);

        // reset mid-burst
        send(0, 16'h1234, c);
        drop(0, 2);
        chk("mid_k", int'(u_dut_a.k_q), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid_a), 0);
        chk("async_rst_data", int'(out_data_a), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 16'd40, c);
        drop(0, 0);
        drain(0);

        // L=2 instance
        send(1, 16'd8, c);
        send(1, 16'd4, c);
        chk("l2_gap", c, 2);
        drop(1, 0);
        drain(1);

        // randomized traffic with random backpressure on both instances
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 16'h0000;
                1:       v = 16'hFFFF;
                default: v = 16'($urandom_range(0, 65535));
            endcase
            send(0, v, c);
            if ($urandom_range(0, 1) == 1) drop(0, $urandom_range(0, 3));
        end
        drop(0, 0);
        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom_range(0, 65535));
            send(1, v, c);
            if ($urandom_range(0, 1) == 1) drop(1, $urandom_range(0, 3));
        end
        drop(1, 0);
        rand_ready  = 1'b0;
        @(posedge clk);
        #2;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        drain(0);
        drain(1);
        repeat (3) @(posedge clk);
        #1;
        chk("end_idle_a", int'(out_valid_a), 0);
        chk("end_idle_b", int'(out_valid_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
